uart_rx_fifo: RTL and testbench

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

---
 rtl/uart_rx_fifo.sv | 181 ++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - UART receiver with configurable framing feeding a first-word-fall-through FIFO
// Errored or overrun frames are dropped and reported through sticky flags.
module uart_rx_fifo #(
  parameter int CLK_PER_HALF_BIT = 30,
  parameter int DATA_BITS        = 8,
  parameter int PARITY           = 0,
  parameter int STOP_BITS        = 1,
  parameter int FIFO_DEPTH       = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rxd,
  input  logic                          rd_en,
  output logic [DATA_BITS-1:0]          rd_data,
  output logic                          empty,
  output logic                          full,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  input  logic                          clr_err,
  output logic                          ferr,
  output logic                          perr,
  output logic                          ovr
);

  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CNTW = AW + 1;
  localparam int CW   = $clog2(2 * CLK_PER_HALF_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLK_PER_HALF_BIT - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(2 * CLK_PER_HALF_BIT - 1);
  localparam logic          ODD     = (PARITY == 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  logic           sync1, sync2, prev;
  logic [1:0]     warm;
  logic           start_edge;

  state_t               state;
  logic [CW-1:0]        cnt;
  logic [3:0]           bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bad, stop_bad;

  logic tick, last_stop, bad_stop, push;
  logic do_push, do_pop, ferr_set, perr_set, ovr_set;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;

  // prev only reflects a real line level once the synchronizer has flushed its
  // reset value, so a line held low through reset never looks like a start edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      prev  <= 1'b0;
      warm  <= 2'd0;
    end else begin
      sync1 <= rxd;
      sync2 <= sync1;
      if (warm != 2'd2) warm <= warm + 2'd1;
      prev  <= (warm == 2'd2) & sync2;
    end
  end

  assign start_edge = prev & ~sync2;

  always_comb begin
    tick      = (state == START) ? (cnt == HALF_M1) : (cnt == FULL_M1);
    last_stop = (state == STOP) && tick && (bit_idx == 4'(STOP_BITS - 1));
    bad_stop  = stop_bad | ~sync2;
    push      = last_stop & ~bad_stop & ~par_bad;
    ferr_set  = last_stop & bad_stop;
    perr_set  = last_stop & par_bad;
    do_pop    = rd_en & ~empty;
    do_push   = push & (~full | rd_en);
    ovr_set   = push & full & ~rd_en;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      par_bad  <= 1'b0;
      stop_bad <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_edge) begin
            state <= START;
            cnt   <= '0;
          end
        end
        START: begin
          if (tick) begin
            cnt      <= '0;
            bit_idx  <= '0;
            par_bad  <= 1'b0;
            stop_bad <= 1'b0;
            state    <= sync2 ? IDLE : DATA;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DATA: begin
          if (tick) begin
            cnt   <= '0;
            shreg <= {sync2, shreg[DATA_BITS-1:1]};
            if (bit_idx == 4'(DATA_BITS - 1)) begin
              bit_idx <= '0;
              state   <= (PARITY == 0) ? STOP : PAR;
            end else begin
              bit_idx <= bit_idx + 4'd1;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        PAR: begin
          if (tick) begin
            cnt     <= '0;
            par_bad <= (^shreg ^ sync2) != ODD;
            state   <= STOP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        STOP: begin
          if (tick) begin
            cnt <= '0;
            if (!sync2) stop_bad <= 1'b1;
            if (last_stop) state <= IDLE;
            else           bit_idx <= bit_idx + 4'd1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= shreg;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNTW'(1);
        2'b01:   count <= count - CNTW'(1);
        default: count <= count;
      endcase
    end
  end

  // A new error event in the same cycle as clr_err keeps its flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ferr <= 1'b0;
      perr <= 1'b0;
      ovr  <= 1'b0;
    end else begin
      ferr <= (ferr & ~clr_err) | ferr_set;
      perr <= (perr & ~clr_err) | perr_set;
      ovr  <= (ovr  & ~clr_err) | ovr_set;
    end
  end

  assign empty   = (count == '0);
  assign full    = (count == CNTW'(FIFO_DEPTH));
  assign rd_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - scoreboard bench for uart_rx_fifo (8N1 and 8E1 instances, depth 4)
module tb_uart_rx_fifo;
  localparam int H      = 30;
  localparam int BP     = 2 * H;
  localparam int PUSH_N = 3 + 19 * H;   // edge of last stop sample, 8N1, counted from the start-bit edge
  localparam int PUSH_E = 3 + 21 * H;   // same for 8E1

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       rxd_n = 1'b1, rd_en_n = 1'b0, clr_n = 1'b0;
  logic [7:0] rd_data_n;
  logic       empty_n, full_n, ferr_n, perr_n, ovr_n;
  logic [2:0] count_n;

  logic       rxd_e = 1'b1, rd_en_e = 1'b0, clr_e = 1'b0;
  logic [7:0] rd_data_e;
  logic       empty_e, full_e, ferr_e, perr_e, ovr_e;
  logic [2:0] count_e;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_n[$];
  logic [7:0] exp_e[$];

  uart_rx_fifo #(.CLK_PER_HALF_BIT(H), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_n (
    .clk(clk), .rst(rst), .rxd(rxd_n), .rd_en(rd_en_n), .rd_data(rd_data_n), .empty(empty_n),
    .full(full_n), .count(count_n), .clr_err(clr_n), .ferr(ferr_n), .perr(perr_n), .ovr(ovr_n));

  uart_rx_fifo #(.CLK_PER_HALF_BIT(H), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_e (
    .clk(clk), .rst(rst), .rxd(rxd_e), .rd_en(rd_en_e), .rd_data(rd_data_e), .empty(empty_e),
    .full(full_e), .count(count_e), .clr_err(clr_e), .ferr(ferr_e), .perr(perr_e), .ovr(ovr_e));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && rd_en_n && !empty_n) begin
      if (exp_n.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL pop_n: got %0h expected no word", rd_data_n);
      end else check("pop_n", rd_data_n, exp_n.pop_front());
    end
  end

  always @(negedge clk) begin
    if (!rst && rd_en_e && !empty_e) begin
      if (exp_e.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL pop_e: got %0h expected no word", rd_data_e);
      end else check("pop_e", rd_data_e, exp_e.pop_front());
    end
  end

  // pop_at / clr_at: index of the clock edge (from the start-bit edge) at which the pulse is sampled
  task automatic send(input int which, input logic [7:0] d, input bit par_flip, input bit stop_ok,
                      input int pop_at, input int clr_at, input bit chk_timing);
    logic [11:0] bits;
    int nb;
    if (which == 0) begin
      bits = {2'b11, stop_ok, d, 1'b0};
      nb   = 10;
    end else begin
      bits = {1'b1, stop_ok, (^d) ^ par_flip, d, 1'b0};
      nb   = 11;
    end
    @(posedge clk);
    for (int i = 0; i < nb * BP; i++) begin
      #1;
      if (which == 0) begin
        rxd_n   = bits[i / BP];
        rd_en_n = (i == pop_at - 1);
        clr_n   = (i == clr_at - 1);
        if (chk_timing && i == PUSH_N - 1) check("empty_before_push", empty_n, 1);
        if (chk_timing && i == PUSH_N)     check("empty_after_push", empty_n, 0);
      end else begin
        rxd_e   = bits[i / BP];
        rd_en_e = (i == pop_at - 1);
        clr_e   = (i == clr_at - 1);
      end
      @(posedge clk);
    end
    #1;
    rxd_n = 1'b1; rd_en_n = 1'b0; clr_n = 1'b0;
    rxd_e = 1'b1; rd_en_e = 1'b0; clr_e = 1'b0;
  endtask

  task automatic pop(input int which);
    @(posedge clk); #1;
    if (which == 0) rd_en_n = 1'b1; else rd_en_e = 1'b1;
    @(posedge clk); #1;
    rd_en_n = 1'b0; rd_en_e = 1'b0;
  endtask

  task automatic clr_pulse_n();
    @(posedge clk); #1 clr_n = 1'b1;
    @(posedge clk); #1 clr_n = 1'b0;
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_n(input string tag, input logic [2:0] c, input logic f, input logic p, input logic o);
    check({tag, "_count"}, count_n, c);
    check({tag, "_ferr"}, ferr_n, f);
    check({tag, "_perr"}, perr_n, p);
    check({tag, "_ovr"}, ovr_n, o);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected test end");
    $fatal(1, "watchdog");
  end

  initial begin
    wait_clks(3);
    check("rst_empty_n", empty_n, 1);
    check("rst_full_n", full_n, 0);
    check("rst_rd_data_n", rd_data_n, 0);
    check_n("rst", 0, 0, 0, 0);
    check("rst_empty_e", empty_e, 1);
    check("rst_count_e", count_e, 0);
    rst = 1'b0;
    wait_clks(5);

    // even parity: good frame, then bad parity bit
    exp_e.push_back(8'h55);
    send(1, 8'h55, 0, 1, -1, -1, 0);
    send(1, 8'h55, 1, 1, -1, -1, 0);
    wait_clks(5);
    check("par_count_e", count_e, 1);
    check("par_perr_e", perr_e, 1);
    check("par_ferr_e", ferr_e, 0);
    check("par_ovr_e", ovr_e, 0);
    pop(1);
    check("par_empty_e", empty_e, 1);

    // 8N1 clean frame with exact push timing
    exp_n.push_back(8'hAA);
    send(0, 8'hAA, 0, 1, -1, -1, 1);
    check_n("aa", 1, 0, 0, 0);
    pop(0);
    check("aa_empty", empty_n, 1);

    // framing error, clear, then error coinciding with clear
    send(0, 8'h3C, 0, 0, -1, -1, 0);
    wait_clks(2);
    check("ferr_empty", empty_n, 1);
    check("ferr_set", ferr_n, 1);
    clr_pulse_n();
    check("ferr_cleared", ferr_n, 0);
    send(0, 8'h3C, 0, 0, -1, PUSH_N, 0);
    check("ferr_set_wins", ferr_n, 1);
    clr_pulse_n();
    check_n("ferr_clr2", 0, 0, 0, 0);

    // 10-clock low glitch
    @(posedge clk); #1 rxd_n = 1'b0;
    wait_clks(10);
    rxd_n = 1'b1;
    wait_clks(100);
    check_n("glitch", 0, 0, 0, 0);

    // overrun: 5 frames into depth 4
    for (int d = 1; d <= 5; d++) begin
      if (d <= 4) exp_n.push_back(8'(d));
      send(0, 8'(d), 0, 1, -1, -1, 0);
    end
    wait_clks(2);
    check_n("ovr", 4, 0, 0, 1);
    check("ovr_full", full_n, 1);
    clr_pulse_n();
    check("ovr_cleared", ovr_n, 0);

    // push while full with a simultaneous pop
    exp_n.push_back(8'h06);
    send(0, 8'h06, 0, 1, PUSH_N, -1, 0);
    check_n("full_pushpop", 4, 0, 0, 0);

    // push and pop together at level 2
    pop(0);
    pop(0);
    exp_n.push_back(8'h07);
    send(0, 8'h07, 0, 1, PUSH_N, -1, 0);
    check("mid_pushpop_count", count_n, 2);
    pop(0);
    pop(0);
    check("drain_empty", empty_n, 1);

    // rd_en while empty
    @(posedge clk); #1 rd_en_n = 1'b1;
    wait_clks(3);
    rd_en_n = 1'b0;
    check("underflow_count", count_n, 0);
    check("underflow_empty", empty_n, 1);

    // reset mid-frame, released with the line still low
    @(posedge clk); #1 rxd_n = 1'b0;
    wait_clks(150);
    rst = 1'b1;
    wait_clks(4);
    rst = 1'b0;
    wait_clks(40);
    check_n("rst_mid_low", 0, 0, 0, 0);
    rxd_n = 1'b1;
    wait_clks(100);
    check_n("rst_mid_idle", 0, 0, 0, 0);
    exp_n.push_back(8'hA5);
    send(0, 8'hA5, 0, 1, -1, -1, 1);
    check_n("a5", 1, 0, 0, 0);
    pop(0);
    check("a5_empty", empty_n, 1);

    wait_clks(2);
    check("exp_n_drained", exp_n.size(), 0);
    check("exp_e_drained", exp_e.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
